// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divide-by-N engine family.
// Holds the FSM state encoding and a constant-foldable clog2.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_by_n_seq_if.sv
// Producer/consumer handshake bundle for div_by_n_seq.
// Operand side and result side are both plain valid/ready.
interface div_by_n_seq_if #(
  parameter int DATA_W = 8,
  parameter int REM_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data;
  logic              out_valid;
  logic              out_ready;
  logic              divisibility;
  logic [REM_W-1:0]  remainder;
  logic              busy;

  modport master (
    output in_valid, data, out_ready,
    input  in_ready, out_valid, divisibility, remainder, busy
  );

  modport slave (
    input  in_valid, data, out_ready,
    output in_ready, out_valid, divisibility, remainder, busy
  );
endinterface

// File: rtl/div_rem_step.sv
// One remainder fold: rem_o = ({rem_i, chunk_i}) % DIVISOR via an elaboration-time table.
// Purely combinational; no backpressure.
module div_rem_step #(
  parameter int DIVISOR = 3,
  parameter int CHUNK_W = 2,
  parameter int REM_W   = 2
) (
  input  logic [REM_W-1:0]   rem_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic [REM_W-1:0]   rem_o
);
  localparam int IDX_W = REM_W + CHUNK_W;
  localparam int DEPTH = DIVISOR << CHUNK_W;

  logic [REM_W-1:0] rem_lut [DEPTH];
  logic [IDX_W-1:0] idx;

  // rem_i < DIVISOR, so idx never reaches DEPTH
  for (genvar g = 0; g < DEPTH; g++) begin : g_lut
    assign rem_lut[g] = REM_W'(g % DIVISOR);
  end

  assign idx   = {rem_i, chunk_i};
  assign rem_o = rem_lut[idx];
endmodule

// File: rtl/div_by_n_seq.sv
// Sequential remainder engine: folds CHUNK_W operand bits per cycle, MSB first, into data % DIVISOR.
// Result valid NCH cycles after accept and held until out_ready; one operand in flight.
module div_by_n_seq
  import div_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DIVISOR = 3,
  parameter int CHUNK_W = 2
) (
  input logic           clk,
  input logic           rst_n,
  div_by_n_seq_if.slave bus
);
  localparam int REM_W = clog2(DIVISOR);
  localparam int NCH   = DATA_W / CHUNK_W;
  localparam int CNT_W = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  rem_d;
  logic [REM_W-1:0]  rem_out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              div_q;
  logic              busy_q;

  div_rem_step #(
    .DIVISOR (DIVISOR),
    .CHUNK_W (CHUNK_W),
    .REM_W   (REM_W)
  ) u_step (
    .rem_i   (rem_q),
    .chunk_i (shreg_q[DATA_W-1 -: CHUNK_W]),
    .rem_o   (rem_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rem_out_q   <= '0;
      div_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            shreg_q    <= bus.data;
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          rem_q   <= rem_d;
          shreg_q <= shreg_q << CHUNK_W;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            out_valid_q <= 1'b1;
            rem_out_q   <= rem_d;
            div_q       <= (rem_d == '0);
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result outputs fall back to reset values so IDLE/RUN always show zeros
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            rem_out_q   <= '0;
            div_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.remainder    = rem_out_q;
  assign bus.divisibility = div_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_div_by_n_seq.sv
// Bench for div_by_n_seq: three parameterisations checked against an arithmetic % model.
module tb_div_by_n_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks;
  int passes;

  // Instance 0: defaults; 1: DIVISOR 7 CHUNK 1; 2: 16-bit CHUNK 4 DIVISOR 5
  int nch  [3] = '{4, 8, 4};
  int divs [3] = '{3, 7, 5};
  int dmask[3] = '{255, 255, 65535};

  logic        iv   [3];
  logic [15:0] dat  [3];
  logic        ordy [3];
  logic        ov   [3];
  logic        ir   [3];
  logic        dv   [3];
  logic        bz   [3];
  logic [3:0]  rm   [3];

  logic [15:0] op_q [$];

  div_by_n_seq_if #(.DATA_W(8),  .REM_W(2)) ia ();
  div_by_n_seq_if #(.DATA_W(8),  .REM_W(3)) ib ();
  div_by_n_seq_if #(.DATA_W(16), .REM_W(3)) ic ();

  div_by_n_seq #(.DATA_W(8),  .DIVISOR(3), .CHUNK_W(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  div_by_n_seq #(.DATA_W(8),  .DIVISOR(7), .CHUNK_W(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  div_by_n_seq #(.DATA_W(16), .DIVISOR(5), .CHUNK_W(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  assign ia.in_valid = iv[0];
  assign ia.data     = 8'(dat[0]);
  assign ia.out_ready = ordy[0];
  assign ib.in_valid = iv[1];
  assign ib.data     = 8'(dat[1]);
  assign ib.out_ready = ordy[1];
  assign ic.in_valid = iv[2];
  assign ic.data     = dat[2];
  assign ic.out_ready = ordy[2];

  assign ov[0] = ia.out_valid;  assign ir[0] = ia.in_ready;  assign dv[0] = ia.divisibility;
  assign bz[0] = ia.busy;       assign rm[0] = {2'b00, ia.remainder};
  assign ov[1] = ib.out_valid;  assign ir[1] = ib.in_ready;  assign dv[1] = ib.divisibility;
  assign bz[1] = ib.busy;       assign rm[1] = {1'b0, ib.remainder};
  assign ov[2] = ic.out_valid;  assign ir[2] = ic.in_ready;  assign dv[2] = ic.divisibility;
  assign bz[2] = ic.busy;       assign rm[2] = {1'b0, ic.remainder};

  // Streams op_q through instance k with out_ready high; checks value, latency and spacing.
  task automatic run_stream(input int k);
    int exp_q[$];
    int acc_q[$];
    int n, got, budget, last_acc, e, t;
    n = op_q.size();
    got = 0;
    budget = 0;
    last_acc = -1;
    ordy[k] = 1'b1;
    while (got < n && budget < 400) begin
      @(negedge clk);
      budget++;
      if (ov[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL spurious_result k=%0d got rem %0d want no result", k, rm[k]);
        end else begin
          passes++;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          got++;
          checks++;
          if (int'(rm[k]) !== e) $display("FAIL remainder k=%0d got %0d want %0d", k, rm[k], e);
          else passes++;
          checks++;
          if (dv[k] !== (e == 0)) $display("FAIL divisibility k=%0d got %0b want %0b", k, dv[k], e == 0);
          else passes++;
          checks++;
          if (cyc !== t + nch[k]) $display("FAIL latency k=%0d got %0d want %0d", k, cyc - t, nch[k]);
          else passes++;
        end
      end else begin
        checks++;
        if ({dv[k], rm[k]} !== 5'd0) $display("FAIL idle_outputs k=%0d got div %0b rem %0d want 0 0", k, dv[k], rm[k]);
        else passes++;
      end
      if (ir[k] && op_q.size() > 0) begin
        dat[k] = op_q.pop_front();
        iv[k] = 1'b1;
        exp_q.push_back(int'(dat[k]) % divs[k]);
        acc_q.push_back(cyc + 1);
        if (last_acc >= 0) begin
          checks++;
          if (cyc + 1 - last_acc !== nch[k] + 2)
            $display("FAIL throughput k=%0d got %0d want %0d", k, cyc + 1 - last_acc, nch[k] + 2);
          else passes++;
        end
        last_acc = cyc + 1;
      end else begin
        iv[k] = 1'b0;
      end
    end
    iv[k] = 1'b0;
    checks++;
    if (got !== n) $display("FAIL stream_timeout k=%0d got %0d results want %0d", k, got, n);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1) $display("FAIL reset_in_ready k=%0d got %0b want 1", k, ir[k]); else passes++;
      checks++;
      if (ov[k] !== 1'b0) $display("FAIL reset_out_valid k=%0d got %0b want 0", k, ov[k]); else passes++;
      checks++;
      if ({dv[k], rm[k]} !== 5'd0) $display("FAIL reset_result k=%0d got %0d/%0d want 0/0", k, dv[k], rm[k]); else passes++;
      checks++;
      if (bz[k] !== 1'b0) $display("FAIL reset_busy k=%0d got %0b want 0", k, bz[k]); else passes++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    op_q = '{16'd5, 16'd12, 16'd37, 16'd29, 16'd33, 16'd45};
    run_stream(0);
  endtask

  task automatic test_edge_values();
    op_q = '{16'd0, 16'd255};
    for (int i = 0; i < 4; i++) op_q.push_back(16'($urandom) & 16'(dmask[0]));
    run_stream(0);
  endtask

  task automatic test_div7();
    op_q = '{16'd200, 16'd196};
    for (int i = 0; i < 4; i++) op_q.push_back(16'($urandom) & 16'(dmask[1]));
    run_stream(1);
  endtask

  task automatic test_div5();
    op_q = '{16'hFFFF, 16'd1234};
    for (int i = 0; i < 4; i++) op_q.push_back(16'($urandom) & 16'(dmask[2]));
    run_stream(2);
  endtask

  task automatic test_backpressure();
    int budget, e;
    logic [7:0] v;
    v = 8'($urandom);
    e = int'(v) % 3;
    ordy[0] = 1'b0;
    budget = 0;
    while (!ir[0] && budget < 50) begin @(negedge clk); budget++; end
    dat[0] = 16'(v);
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    budget = 0;
    while (!ov[0] && budget < 50) begin @(negedge clk); budget++; end
    checks++;
    if (ov[0] !== 1'b1) $display("FAIL bp_result_timeout got out_valid %0b want 1", ov[0]); else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[0] !== 1'b1) $display("FAIL bp_hold_valid cycle %0d got %0b want 1", i, ov[0]); else passes++;
      checks++;
      if (int'(rm[0]) !== e || dv[0] !== (e == 0))
        $display("FAIL bp_hold_result cycle %0d got %0d/%0b want %0d/%0b", i, rm[0], dv[0], e, e == 0);
      else passes++;
      checks++;
      if (ir[0] !== 1'b0 || bz[0] !== 1'b1)
        $display("FAIL bp_flags cycle %0d got ready %0b busy %0b want 0 1", i, ir[0], bz[0]);
      else passes++;
      iv[0] = (i % 2 == 0);
      dat[0] = 16'($urandom) & 16'h00FF;
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
      $display("FAIL bp_release got valid %0b ready %0b want 0 1", ov[0], ir[0]);
    else passes++;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1 || bz[0] !== 1'b0)
      $display("FAIL bp_no_accept got ready %0b busy %0b want 1 0", ir[0], bz[0]);
    else passes++;
    op_q = '{16'($urandom) & 16'h00FF};
    run_stream(0);
  endtask

  task automatic test_reset_mid_run();
    int budget;
    ordy[0] = 1'b1;
    budget = 0;
    while (!ir[0] && budget < 50) begin @(negedge clk); budget++; end
    dat[0] = 16'd37;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bz[0] !== 1'b1 || ov[0] !== 1'b0) $display("FAIL midrun_state got busy %0b valid %0b want 1 0", bz[0], ov[0]);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || {dv[0], rm[0]} !== 5'd0)
      $display("FAIL midrun_reset got ready %0b valid %0b busy %0b div %0b rem %0d want 1 0 0 0 0",
               ir[0], ov[0], bz[0], dv[0], rm[0]);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b0) $display("FAIL midrun_no_result cycle %0d got %0b want 0", i, ov[0]); else passes++;
    end
    op_q = '{16'd12};
    run_stream(0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      dat[k] = '0;
      ordy[k] = 1'b0;
    end
    test_reset();
    test_back_to_back();
    test_edge_values();
    test_div7();
    test_div5();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
